// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: LMS adaptation sequencer (init pulse, decimated/frozen update enable, mu gear shift); optional lock monitor under LMS_LOCK_DETECT_EN
module lms_adapt_ctrl #(
  parameter int                 ACQ_LEN    = 4096,
  parameter logic signed [7:0]  MU_ACQ     = 8'sd32,
  parameter logic signed [7:0]  MU_TRK     = 8'sd4,
  parameter int                 AVG_SHIFT  = 5,
  parameter logic [6:0]         LOCK_THR   = 7'd16,
  parameter logic [6:0]         UNLOCK_THR = 7'd48
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_restart,
  input  logic       i_sym_valid,
  input  logic       i_freeze,
  input  logic [3:0] i_dec,
  input  logic [7:0] i_error,
  output logic       o_lms_en,
  output logic       o_lms_rst,
  output logic [7:0] o_mu,
  output logic [1:0] o_state,
  output logic       o_locked
);
  localparam int CW = $clog2(ACQ_LEN);
  typedef enum logic [1:0] {IDLE, INIT, ACQ, TRK} state_t;
  state_t state, nxt;
  logic [CW-1:0] sym_cnt;
  logic [3:0] dec_cnt, dec_lim;
  logic run, qual, acq_done, lol;
  assign run      = state == ACQ || state == TRK;
  assign qual     = run && i_sym_valid && dec_cnt == 4'd0 && !i_freeze;
  assign acq_done = state == ACQ && qual && sym_cnt == CW'(ACQ_LEN - 1);
  // state register
  always_ff @(posedge i_clk)
    if (!i_rst_n) state <= IDLE;
    else state <= nxt;
  // next state: !enable > restart > loss of lock > acquisition expiry
  always_comb
    nxt = !i_enable ? IDLE :
          i_restart ? INIT :
          state == IDLE ? INIT :
          state == INIT ? ACQ :
          lol ? INIT :
          acq_done ? TRK : state;
  // state-decoded outputs; mu switches together with the state
  always_comb begin
    o_state   = state;
    o_lms_rst = state == INIT;
    o_mu      = state == ACQ ? MU_ACQ : state == TRK ? MU_TRK : 8'd0;
  end
  // decimation/symbol counters and update pulse; the decimation limit reloads only at wrap
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      sym_cnt  <= '0;
      dec_cnt  <= '0;
      dec_lim  <= '0;
      o_lms_en <= 1'b0;
    end else if (state == INIT) begin
      sym_cnt  <= '0;
      dec_cnt  <= '0;
      dec_lim  <= i_dec;
      o_lms_en <= 1'b0;
    end else begin
      o_lms_en <= qual && (nxt == ACQ || nxt == TRK);
      if (run && i_sym_valid) begin
        dec_cnt <= dec_cnt == dec_lim ? 4'd0 : dec_cnt + 4'd1;
        if (dec_cnt == dec_lim) dec_lim <= i_dec;
      end
      if (state == ACQ && qual) sym_cnt <= sym_cnt + CW'(1);
    end
`ifdef LMS_LOCK_DETECT_EN
  localparam int AW = 7 + AVG_SHIFT;
  logic [AW-1:0] avg, avg_nxt;
  logic [6:0] mag, mean;
  // |e| with -128 saturated to 127, and the leaky average update
  always_comb begin
    mag     = i_error == 8'h80 ? 7'd127 : i_error[7] ? 7'(-i_error) : i_error[6:0];
    avg_nxt = run && i_sym_valid ? avg + AW'(mag) - (avg >> AVG_SHIFT) : avg;
    mean    = 7'(avg >> AVG_SHIFT);
    lol     = state == TRK && mean > UNLOCK_THR;
  end
  // average register and registered lock flag aligned with the next state
  always_ff @(posedge i_clk)
    if (!i_rst_n || state == INIT) begin
      avg      <= '0;
      o_locked <= 1'b0;
    end else begin
      avg      <= avg_nxt;
      o_locked <= nxt == TRK && 7'(avg_nxt >> AVG_SHIFT) <= LOCK_THR;
    end
`else
  logic unused;
  assign unused   = ^{i_error, LOCK_THR, UNLOCK_THR, AVG_SHIFT[0]};
  assign lol      = 1'b0;
  assign o_locked = state == TRK;
`endif
endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb_lms_adapt_ctrl: directed self-checking bench for lms_adapt_ctrl
module tb_lms_adapt_ctrl;
  logic i_clk = 1'b0, i_rst_n, i_enable, i_restart, i_sym_valid, i_freeze;
  logic [3:0] i_dec;
  logic [7:0] i_error;
  logic o_lms_en, o_lms_rst, o_locked;
  logic [7:0] o_mu;
  logic [1:0] o_state;
  int checks = 0, passed = 0;

  lms_adapt_ctrl #(.ACQ_LEN(16), .AVG_SHIFT(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_restart(i_restart),
    .i_sym_valid(i_sym_valid), .i_freeze(i_freeze), .i_dec(i_dec), .i_error(i_error),
    .o_lms_en(o_lms_en), .o_lms_rst(o_lms_rst), .o_mu(o_mu), .o_state(o_state), .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  task tick;
    @(posedge i_clk);
    #1;
  endtask

  task test_reset;
    i_rst_n = 0; i_enable = 1; i_restart = 0; i_sym_valid = 0; i_freeze = 0; i_dec = 0; i_error = 8'd8;
    tick; tick;
    checks++; if ({o_state, o_lms_en, o_lms_rst, o_mu, o_locked} !== 13'd0) $display("FAIL reset_outputs got st=%0d en=%0d rst=%0d mu=%0d lk=%0d exp all 0", o_state, o_lms_en, o_lms_rst, o_mu, o_locked); else passed++;
    i_rst_n = 1;
    tick;
    checks++; if (o_state !== 2'd1 || o_lms_rst !== 1'b1 || o_mu !== 8'd0) $display("FAIL reset_init got st=%0d rst=%0d mu=%0d exp 1 1 0", o_state, o_lms_rst, o_mu); else passed++;
    tick;
    checks++; if (o_state !== 2'd2 || o_lms_rst !== 1'b0 || o_mu !== 8'd32) $display("FAIL reset_acq got st=%0d rst=%0d mu=%0d exp 2 0 32", o_state, o_lms_rst, o_mu); else passed++;
  endtask

  task test_acq;
    for (int k = 0; k < 16; k++) begin
      i_sym_valid = 1;
      tick;
      i_sym_valid = 0;
      checks++; if (o_lms_en !== 1'b1) $display("FAIL acq_pulse%0d got %0d exp 1", k, o_lms_en); else passed++;
      checks++; if (o_mu !== (k < 15 ? 8'd32 : 8'd4) || o_state !== (k < 15 ? 2'd2 : 2'd3)) $display("FAIL acq_gear%0d got mu=%0d st=%0d exp %0d %0d", k, o_mu, o_state, k < 15 ? 32 : 4, k < 15 ? 2 : 3); else passed++;
      tick;
      checks++; if (o_lms_en !== 1'b0) $display("FAIL acq_pulse_width%0d got %0d exp 0", k, o_lms_en); else passed++;
      tick; tick;
    end
    checks++; if (o_locked !== 1'b1 || o_state !== 2'd3 || o_mu !== 8'd4) $display("FAIL trk_entry got lk=%0d st=%0d mu=%0d exp 1 3 4", o_locked, o_state, o_mu); else passed++;
  endtask

  task test_restart;
    i_restart = 1;
    tick;
    i_restart = 0;
    checks++; if (o_state !== 2'd1 || o_lms_rst !== 1'b1 || o_mu !== 8'd0 || o_locked !== 1'b0) $display("FAIL restart_init got st=%0d rst=%0d mu=%0d lk=%0d exp 1 1 0 0", o_state, o_lms_rst, o_mu, o_locked); else passed++;
    tick;
    checks++; if (o_state !== 2'd2 || o_lms_rst !== 1'b0 || o_mu !== 8'd32) $display("FAIL restart_acq got st=%0d rst=%0d mu=%0d exp 2 0 32", o_state, o_lms_rst, o_mu); else passed++;
  endtask

  task test_decimation;
    i_dec = 2; i_restart = 1;
    tick;
    i_restart = 0;
    tick;
    for (int p = 0; p < 2; p++)
      for (int s = 1; s <= 12; s++) begin
        i_sym_valid = 1; i_freeze = p == 1 && s == 4;
        tick;
        i_sym_valid = 0; i_freeze = 0;
        checks++; if (o_lms_en !== ((s % 3 == 1) && !(p == 1 && s == 4))) $display("FAIL dec_p%0d_s%0d got %0d exp %0d", p, s, o_lms_en, (s % 3 == 1) && !(p == 1 && s == 4)); else passed++;
        tick;
      end
  endtask

  task test_enable_drop;
    i_sym_valid = 1; i_enable = 0;
    tick;
    i_sym_valid = 0;
    checks++; if (o_state !== 2'd0 || o_lms_en !== 1'b0 || o_mu !== 8'd0) $display("FAIL enable_drop got st=%0d en=%0d mu=%0d exp 0 0 0", o_state, o_lms_en, o_mu); else passed++;
    i_enable = 1; i_dec = 0;
    tick;
    checks++; if (o_state !== 2'd1 || o_lms_rst !== 1'b1) $display("FAIL reenable_init got st=%0d rst=%0d exp 1 1", o_state, o_lms_rst); else passed++;
    tick;
  endtask

  task test_back_to_back;
    i_sym_valid = 1;
    for (int k = 0; k < 16; k++) begin
      tick;
      checks++; if (o_lms_en !== 1'b1 || o_state !== (k < 15 ? 2'd2 : 2'd3)) $display("FAIL b2b%0d got en=%0d st=%0d exp 1 %0d", k, o_lms_en, o_state, k < 15 ? 2 : 3); else passed++;
    end
    i_sym_valid = 0;
    tick;
    checks++; if (o_lms_en !== 1'b0 || o_locked !== 1'b1) $display("FAIL b2b_end got en=%0d lk=%0d exp 0 1", o_lms_en, o_locked); else passed++;
  endtask

  task test_lock;
    i_error = 8'h80;
`ifdef LMS_LOCK_DETECT_EN
    begin
      bit seen_init = 0;
      i_sym_valid = 1;
      tick;
      i_sym_valid = 0;
      checks++; if (o_locked !== 1'b0 || o_state !== 2'd3) $display("FAIL lock_drop got lk=%0d st=%0d exp 0 3", o_locked, o_state); else passed++;
      for (int k = 0; k < 20 && !seen_init; k++) begin
        i_sym_valid = 1;
        tick;
        i_sym_valid = 0;
        seen_init = o_state == 2'd1;
        if (!seen_init) tick;
      end
      checks++; if (!seen_init || o_lms_rst !== 1'b1 || o_lms_en !== 1'b0) $display("FAIL unlock_init got seen=%0d rst=%0d en=%0d exp 1 1 0", seen_init, o_lms_rst, o_lms_en); else passed++;
      tick;
      checks++; if (o_state !== 2'd2 || o_mu !== 8'd32 || o_locked !== 1'b0) $display("FAIL unlock_acq got st=%0d mu=%0d lk=%0d exp 2 32 0", o_state, o_mu, o_locked); else passed++;
    end
`else
    for (int k = 0; k < 20; k++) begin
      i_sym_valid = 1;
      tick;
      i_sym_valid = 0;
      checks++; if (o_locked !== 1'b1 || o_state !== 2'd3) $display("FAIL nolock%0d got lk=%0d st=%0d exp 1 3", k, o_locked, o_state); else passed++;
      tick;
    end
`endif
    i_error = 8'd8;
  endtask

  task test_reset_mid;
    i_sym_valid = 1; i_rst_n = 0;
    tick;
    i_sym_valid = 0;
    checks++; if ({o_state, o_lms_en, o_lms_rst, o_mu, o_locked} !== 13'd0) $display("FAIL reset_mid got st=%0d en=%0d rst=%0d mu=%0d lk=%0d exp all 0", o_state, o_lms_en, o_lms_rst, o_mu, o_locked); else passed++;
    i_rst_n = 1;
  endtask

  initial begin
    test_reset;
    test_acq;
    test_restart;
    test_decimation;
    test_enable_drop;
    test_back_to_back;
    test_lock;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/lms_adapt_ctrl.md
# lms_adapt_ctrl

Adaptation controller for the LMS coefficient-update block of the equalizer. It sequences adaptation from a symbol strobe: it issues the one-cycle coefficient re-initialisation pulse, gates the update enable (decimation and freeze), and switches the step size from acquisition gear to tracking gear. An optional error-magnitude monitor reports lock and forces re-acquisition on loss of lock. It sits between the receiver control/config registers and the LMS block's enable, reset and mu inputs.

## Interface
- ACQ_LEN, 4096: valid symbols spent in acquisition before switching to tracking (≥2).
- MU_ACQ, 8'sd32: acquisition step size, S(8,7) (0.25).
- MU_TRK, 8'sd4: tracking step size, S(8,7) (0.03125).
- AVG_SHIFT, 5: leaky-average time constant, 2^AVG_SHIFT symbols.
- LOCK_THR, 7'd16: mean |e| at or below which o_locked is set, U(7,7).
- UNLOCK_THR, 7'd48: mean |e| above which tracking aborts to re-acquire, U(7,7).
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_enable  in  1  adaptation master enable (level).
- i_restart  in  1  single-cycle request to re-initialise and re-acquire.
- i_sym_valid  in  1  one-cycle strobe per equalised symbol.
- i_freeze  in  1  level; suppresses coefficient updates.
- i_dec  in  4  update every i_dec+1 symbols.
- i_error  in  8  slicer error S(8,7), valid with i_sym_valid.
- o_lms_en  out  1  LMS update enable, one-cycle pulses.
- o_lms_rst  out  1  coefficient re-init pulse for the LMS block.
- o_mu  out  8  step size S(8,7).
- o_state  out  2  IDLE=0, INIT=1, ACQ=2, TRK=3.
- o_locked  out  1  lock indication.

## Operation
- Reset (i_rst_n=0 at a clock edge): state IDLE; all outputs 0; symbol counter, decimation counter and average cleared.
- Transition priority: reset > !i_enable > i_restart > loss of lock > acquisition-count expiry.
- IDLE: i_enable=1 -> INIT.
- INIT: lasts exactly one cycle. o_lms_rst=1 for that cycle. Clears counters and average. Then -> ACQ.
- ACQ: o_mu=MU_ACQ. The symbol counter increments on each update-producing symbol. When a qualifying update occurs at count ACQ_LEN-1 -> TRK.
- TRK: o_mu=MU_TRK.
- Any state with i_enable=0 -> IDLE next cycle. A pending o_lms_en pulse is dropped.
- i_restart=1 with i_enable=1 in any state (including INIT) -> INIT.
- Decimation counter: in ACQ/TRK, it advances on every i_sym_valid, including frozen symbols, and wraps 0..i_dec. A symbol qualifies when the counter is 0 and i_freeze=0.
- o_lms_en: registered, set the cycle after a qualifying i_sym_valid. Never asserted in IDLE/INIT.
- o_mu: 0 in IDLE/INIT. It changes in the same cycle as o_state.
- i_dec changes take effect at the next wrap. If i_dec=0, every symbol qualifies.

## Timing
- i_sym_valid at edge n -> o_lms_en high for cycle n+1 only.
- i_enable rising at edge n -> INIT (o_lms_rst=1) during cycle n+1, ACQ from cycle n+2.
- When the ACQ_LEN-th update is issued, o_state=TRK and o_mu=MU_TRK in the same cycle as that o_lms_en pulse.
- Back-to-back i_sym_valid on consecutive cycles is supported.
- Reset mid-acquisition or mid-tracking: outputs are 0 at the next edge, with no o_lms_rst pulse.

## Configuration
- LMS_LOCK_DETECT_EN defined:
  - In ACQ/TRK on each i_sym_valid: avg <= avg + |e| - (avg >> AVG_SHIFT).
  - avg is unsigned, 7+AVG_SHIFT bits. |−128| saturates to 127.
  - Mean = avg >> AVG_SHIFT.
  - o_locked = (state==TRK) && mean ≤ LOCK_THR, registered.
  - In TRK, mean > UNLOCK_THR -> INIT.
- LMS_LOCK_DETECT_EN undefined:
  - No average logic and no loss-of-lock transition.
  - o_locked = (state==TRK).
  - LOCK_THR, UNLOCK_THR and AVG_SHIFT are unused.

## Test plan
- Reset with i_enable=1, then release: o_state goes 0->1->2 on successive cycles, and o_lms_rst is high for exactly one cycle.
- ACQ_LEN=16, i_dec=0, i_sym_valid every 4 cycles: 16 o_lms_en pulses with o_mu=32, each one cycle after its strobe. o_state=3 and o_mu=4 from the 16th pulse onward.
- i_dec=2, 12 strobes: pulses on strobes 1, 4, 7, 10 only. Add i_freeze=1 on strobe 4: that pulse is suppressed and strobe 7 still pulses.
- In TRK, pulse i_restart=1: INIT, with one o_lms_rst pulse, then ACQ with o_mu=32. Drop i_enable with a strobe pending: IDLE next cycle, no pulse.
- LMS_LOCK_DETECT_EN, AVG_SHIFT=2, in TRK, i_error=8 steady: o_locked=1. Switch to i_error=-128 (|e|=127): o_locked drops, then INIT once mean > 48, then ACQ.
- Without the macro, same stimulus: o_locked=1 throughout TRK and the state remains 3.
